// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file for the RV32I core.
// NUM_READ registered read ports, one write port, hardwired-zero x0, a
// sequenced post-reset clear of every entry, and a registered a0 debug tap.
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   -> write-first: a same-edge write to a read address is forwarded
//   undefined -> read-first: a same-edge read returns the pre-write contents
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int A0_INDEX   = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ad,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    input  logic                           we3,
    input  logic [ADDR_WIDTH-1:0]          ad3,
    input  logic [DATA_WIDTH-1:0]          wd3,
    output logic [DATA_WIDTH-1:0]          a0,
    output logic                           busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [DATA_WIDTH-1:0]   rf [DEPTH];
    logic [NUM_READ*DATA_WIDTH-1:0] rd_next;
    logic [DATA_WIDTH-1:0]   a0_next;
    logic                    user_we;

    // A user write only lands in IDLE, outside reset, and never on x0.
    assign user_we = (state == IDLE) && !rst && we3 && (ad3 != '0);

    // Storage: the clear sequence zeroes one entry per cycle, otherwise the write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the CLEAR sequence zeroes it
        // entry by entry so the storage can still map onto plain RAM.
        if (!rst) begin
            if (state == CLEAR)
                rf[idx] <= '0;
            else if (user_we)
                rf[ad3] <= wd3;
        end
    end

    // Next read data per port and for the a0 tap; x0 always reads zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic [ADDR_WIDTH-1:0] ra;
            ra = ad[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_next[i*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : rf[ra];
`ifdef REG_FILE_BYPASS_EN
            if (user_we && (ra == ad3))
                rd_next[i*DATA_WIDTH +: DATA_WIDTH] = wd3;
`endif
        end
        a0_next = (A0_ADDR == '0) ? '0 : rf[A0_ADDR];
`ifdef REG_FILE_BYPASS_EN
        if (user_we && (A0_ADDR == ad3))
            a0_next = wd3;
`endif
    end

    // Control FSM: clear sweep after reset, then registered reads in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
            rd    <= '0;
            a0    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + 1'b1;
                    rd  <= '0;
                    a0  <= '0;
                    if (&idx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    rd <= rd_next;
                    a0 <= a0_next;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp with four read ports.
// Stimulus pushes expected outputs tagged with the cycle they must appear in;
// a negedge monitor pops and compares them against the DUT.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [31:0] SAME_X7 = 32'h1234_5678;
    localparam logic [31:0] SAME_A0 = 32'hA5A5_A5A5;
`else
    localparam logic [31:0] SAME_X7 = 32'h0000_0001;
    localparam logic [31:0] SAME_A0 = 32'h0000_0000;
`endif

    // kinds: 0..3 = rd port, 4 = a0, 5 = busy
    typedef struct {
        int          kind;
        logic [31:0] val;
        int          due;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NR*AW-1:0]  ad;
    logic [NR*DW-1:0]  rd;
    logic              we3;
    logic [AW-1:0]     ad3;
    logic [DW-1:0]     wd3;
    logic [DW-1:0]     a0;
    logic              busy;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    reg_file_mp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_READ  (NR),
        .A0_INDEX  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ad  (ad),
        .rd  (rd),
        .we3 (we3),
        .ad3 (ad3),
        .wd3 (wd3),
        .a0  (a0),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "rd0";
            1: return "rd1";
            2: return "rd2";
            3: return "rd3";
            4: return "a0";
            default: return "busy";
        endcase
    endfunction

    // Monitor: outputs are stable at the negedge; compare every entry due now.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.kind < 4)
                act = rd[e.kind*DW +: DW];
            else if (e.kind == 4)
                act = a0;
            else
                act = {31'b0, busy};
            checks++;
            if (e.due != cyc) begin
                errors++;
                $display("FAIL %s cycle %0d: expectation due at cycle %0d was never compared",
                         kname(e.kind), cyc, e.due);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d: got %08h, expected %08h",
                         kname(e.kind), cyc, act, e.val);
            end
        end
    end

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wdat, input logic [AW-1:0] p0,
                         input logic [AW-1:0] p1, input logic [AW-1:0] p2,
                         input logic [AW-1:0] p3);
        rst = r;
        we3 = we;
        ad3 = wa;
        wd3 = wdat;
        ad  = {p3, p2, p1, p0};
    endtask

    // Expected value visible after the next rising edge.
    task automatic expect_v(input int kind, input logic [31:0] v);
        sbq.push_back('{kind, v, cyc + 1});
    endtask

    task automatic expect_all_zero();
        for (int p = 0; p < 5; p++) expect_v(p, 32'h0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rst_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3, 5'd4);
        expect_v(5, 32'd1);
        expect_all_zero();
        step();
    endtask

    // n cycles of the clear sweep with rst low; busy holds for 31 samples, falls on the 32nd.
    task automatic clear_run(input int n, input logic we, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wdat);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, we, wa, wdat, 5'(k % 31 + 1), 5'((k + 7) % 31 + 1),
                  5'((k + 14) % 31 + 1), 5'(10));
            expect_v(5, (k < 31) ? 32'd1 : 32'd0);
            expect_all_zero();
            step();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();

        // Reset state and initial clear
        rst_cycle();
        rst_cycle();
        clear_run(32, 1'b0, 5'd0, 32'h0);

        // Fill every register with garbage while reading x0 on all ports
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, 5'(i), 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101),
                  5'd0, 5'd0, 5'd0, 5'd0);
            for (int p = 0; p < 4; p++) expect_v(p, 32'h0);
            step();
        end

        // One-cycle reset pulse must clear everything in exactly 32 busy cycles
        rst_cycle();
        clear_run(32, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(4*k), 5'(4*k + 1), 5'(4*k + 2), 5'(4*k + 3));
            expect_all_zero();
            step();
        end

        // Basic write then dual read of the same entry
        drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd0, 5'd0);
        expect_v(0, 32'hDEAD_BEEF);
        expect_v(1, 32'hDEAD_BEEF);
        expect_v(2, 32'h0);
        expect_v(3, 32'h0);
        step();

        // x0 stays zero, both on the writing edge and afterwards
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        expect_v(0, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 5'd0, 5'd0);
        expect_v(0, 32'h0);
        expect_v(1, 32'hDEAD_BEEF);
        step();

        // Same-edge read/write of x7 (previously 1)
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd0, 5'd5);
        expect_v(0, SAME_X7);
        expect_v(1, SAME_X7);
        expect_v(3, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd0, 5'd0);
        expect_v(0, 32'h1234_5678);
        step();

        // a0 tap with four distinct read addresses
        drive(1'b0, 1'b1, 5'd1, 32'h1111_1111, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd2, 32'h2222_2222, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd10, 32'hA5A5_A5A5, 5'd5, 5'd7, 5'd1, 5'd2);
        expect_v(0, 32'hDEAD_BEEF);
        expect_v(1, 32'h1234_5678);
        expect_v(2, 32'h1111_1111);
        expect_v(3, 32'h2222_2222);
        expect_v(4, SAME_A0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 5'd0, 5'd0);
        expect_v(0, 32'hA5A5_A5A5);
        expect_v(4, 32'hA5A5_A5A5);
        step();

        // Reset mid-clear restarts the sweep; writes during busy are dropped
        rst_cycle();
        clear_run(15, 1'b0, 5'd0, 32'h0);
        rst_cycle();
        clear_run(32, 1'b1, 5'd3, 32'h0000_0099);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 5'd10, 5'd7);
        expect_all_zero();
        expect_v(5, 32'd0);
        step();

        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the RV32I core, successor to the single-configuration 2-read/1-write file. It provides NUM_READ registered read ports, one write port, hardwired-zero register 0, and a sequenced post-reset clear of every entry. It also provides a registered debug tap of the ABI `a0` register for the top-level result output. It sits between decode (addresses) and execute (operands), with writeback driving the write port.

## Interface

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_READ, 2, number of read ports (1..4)
- A0_INDEX, 10, register index driven on `a0`

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ad  in  NUM_READ*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd  out  NUM_READ*DATA_WIDTH  read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- we3  in  1  write enable
- ad3  in  ADDR_WIDTH  write address
- wd3  in  DATA_WIDTH  write data
- a0  out  DATA_WIDTH  registered contents of register A0_INDEX
- busy  out  1  high while the clear sequence runs; writes are dropped and reads return 0

## Operation

- FSM states:
  - CLEAR: entered on any cycle with rst=1; clear index idx is held at 0.
  - After rst falls, one entry idx is written to 0 per cycle and idx increments.
  - After entry DEPTH-1 is written, the next state is IDLE.
  - IDLE: normal operation. Remains in IDLE until rst.
- Reset mid-clear or mid-operation restarts CLEAR at idx=0. Prior array contents are irrelevant because every entry is overwritten.
- Write: in IDLE, when we3=1 and ad3≠0, entry ad3 takes wd3 at the clock edge. Writes with ad3=0 are dropped. Writes in CLEAR are dropped silently, with no stall and no error.
- Read: in IDLE, each rd port i registers rf[ad_i]. A read of address 0 always returns 0, regardless of bypass or a write to 0.
- a0 tracks register A0_INDEX under the same rules as a read port whose address is fixed at A0_INDEX.
- Multiple read ports may address the same entry; all return identical data.
- Read-during-write to the same address follows the configuration below.

## Timing

- Read latency is 1 cycle: an address presented at edge N produces data valid after edge N.
- Write is visible to a read issued on the following cycle, in both configurations.
- Reset values: rd=0 on all ports, a0=0, busy=1, idx=0.
- busy is 1 while rst=1 and for exactly DEPTH cycles after rst deasserts. It falls on the edge that completes the write of entry DEPTH-1. For DEPTH=32 this is 32 cycles.
- rd and a0 output 0 on every cycle where the state at the sampling edge is CLEAR.
- The first valid read is the address presented in the first IDLE cycle; its data appears one cycle later.

## Configuration

- Macro: REG_FILE_BYPASS_EN.
- Defined (write-first): if in IDLE we3=1, ad3≠0, and ad_i==ad3 on the same edge, rd_i registers wd3. The same rule applies to a0 when ad3==A0_INDEX.
- Undefined (read-first): rd_i registers the pre-write contents of the entry. The new value is visible on the next read.
- All other behaviour is identical in both configurations.

## Test plan

- Reset clear: preload garbage by forcing the array, then pulse rst for 1 cycle.
  - Required: busy=1 for exactly 32 cycles after rst falls.
  - Required: every register then reads 0x00000000.
- Basic write/read: in IDLE, write x5=0xDEADBEEF, then read ad0=5 and ad1=5 on the next cycle.
  - Required: both rd ports = 0xDEADBEEF one cycle after the address.
- x0 hardwired: write x0=0xFFFFFFFF, then read ad0=0.
  - Required: rd0=0.
- Same-cycle read/write: write x7=0x12345678 and read ad0=7 on the same edge, where x7 was previously 0x1.
  - Required with REG_FILE_BYPASS_EN: rd0=0x12345678.
  - Required without REG_FILE_BYPASS_EN: rd0=0x00000001.
- a0 tap and NUM_READ=4: write x10=0xA5A5A5A5 with four distinct read addresses active.
  - Required: a0=0xA5A5A5A5 on the next cycle.
  - Required: each rd port returns its own register.
- Reset mid-clear, then write during busy:
  - Assert rst at clear cycle 15; busy must remain 1 for a full 32 cycles after the second release.
  - A write of x3=0x99 issued while busy=1 must be dropped; x3 reads 0 in IDLE.
